// File: rtl/rf_dump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package rf_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks every register through one async read port, emitting (index, data)
// beats on a valid/ready stream while accumulating a wrapping checksum.
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      index_q    <= '0;
      data_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      index_q    <= index_d;
      data_q     <= data_d;
      checksum_q <= checksum_d;
    end
  end

  // The beat registers only load in READ, so they stay frozen through any EMIT stall.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    index_d    = index_q;
    data_d     = data_q;
    checksum_d = checksum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          checksum_d = '0;
          idx_d      = '0;
          state_d    = READ;
        end
      end
      READ: begin
        data_d  = rf_data;
        index_d = idx_q;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          checksum_d = checksum_q + data_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf_addr   = (state_q == READ || state_q == EMIT) ? idx_q : '0;
  assign out_valid = (state_q == EMIT);
  assign out_index = index_q;
  assign out_data  = data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed self-checking bench for rf_dump_reader driving a behavioural
// register file on its read port.
module tb_rf_dump_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  rfAddr;
  logic [31:0] rfData;
  logic        outValid;
  logic        outReady;
  logic [4:0]  outIndex;
  logic [31:0] outData;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] regs    [32];
  logic [31:0] expData [32];
  int          checks;
  int          errors;
  int          cyc;

  rf_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rf_addr   (rfAddr),
    .rf_data   (rfData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_index (outIndex),
    .out_data  (outData),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  assign rfData = regs[rfAddr];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rfReset();
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[2] = 32'h0000_2ffc;
  endtask

  // One complete dump from a start pulse; cyc counts cycles after the start cycle.
  task automatic applyStimulus(input logic [31:0] expCks, input int stallBeat, input int stallLen,
                               input int restartBeat, input bit restartAtDone,
                               input int resetBeat, input int doneCyc);
    logic [31:0] sum;
    bit          got;
    int          expCyc;
    sum = 32'h0;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_cks_clear", checksum, 0);
    checkOutput("start_valid_low", outValid, 0);
    for (int k = 0; k < 32; k++) begin
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        if (outValid) got = 1'b1;
        else step();
      end
      checkOutput($sformatf("beat%0d_seen", k), got, 1);
      if (!got) return;
      expCyc = 2 + 2 * k + ((stallBeat >= 0 && k > stallBeat) ? stallLen : 0);
      checkOutput($sformatf("beat%0d_cycle", k), cyc, expCyc);
      checkOutput($sformatf("beat%0d_index", k), outIndex, k);
      checkOutput($sformatf("beat%0d_data", k), outData, expData[k]);
      checkOutput($sformatf("beat%0d_rfaddr", k), rfAddr, k);
      checkOutput($sformatf("beat%0d_cks", k), checksum, sum);
      if (k == resetBeat) begin
        reset = 1'b1;
        step();
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cks", checksum, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_index", outIndex, 0);
        checkOutput("rst_data", outData, 0);
        checkOutput("rst_rfaddr", rfAddr, 0);
        reset = 1'b0;
        return;
      end
      if (k == stallBeat) begin
        outReady = 1'b0;
        for (int s = 1; s <= stallLen; s++) begin
          step();
          checkOutput($sformatf("stall%0d_valid", s), outValid, 1);
          checkOutput($sformatf("stall%0d_index", s), outIndex, k);
          checkOutput($sformatf("stall%0d_data", s), outData, expData[k]);
          checkOutput($sformatf("stall%0d_cks", s), checksum, sum);
          if (s == stallLen) outReady = 1'b1;
        end
      end
      if (k == restartBeat) start = 1'b1;
      sum = sum + expData[k];
      step();
      start = 1'b0;
    end
    checkOutput("done_cycle", cyc, doneCyc);
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 1);
    checkOutput("done_rfaddr", rfAddr, 0);
    checkOutput("done_cks", checksum, expCks);
    if (restartAtDone) start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("idle_done_low", done, 0);
    checkOutput("idle_busy_low", busy, 0);
    checkOutput("idle_valid_low", outValid, 0);
    checkOutput("idle_cks_hold", checksum, expCks);
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    outReady = 1'b1;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rfReset();
    step();
    step();
    checkOutput("reset_valid", outValid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_cks", checksum, 0);
    checkOutput("reset_index", outIndex, 0);
    checkOutput("reset_data", outData, 0);
    checkOutput("reset_rfaddr", rfAddr, 0);
    reset = 1'b0;
    step();
    checkOutput("idle_stays", busy, 0);

    // Freshly reset register file: only x2 is nonzero.
    for (int i = 0; i < 32; i++) expData[i] = 32'h0;
    expData[2] = 32'h0000_2ffc;
    applyStimulus(32'h0000_2ffc, -1, 0, -1, 1'b0, -1, 65);

    // x_i = i, written while idle.
    step();
    checkOutput("write_idle", busy, 0);
    for (int i = 1; i < 32; i++) begin
      regs[i]    = i;
      expData[i] = i;
    end
    expData[0] = 32'h0;
    applyStimulus(32'h0000_01F0, -1, 0, -1, 1'b0, -1, 65);

    // Starts on the first idle cycle after done, with a 5-cycle stall on beat 7.
    applyStimulus(32'h0000_01F0, 7, 5, -1, 1'b0, -1, 70);

    // Restart pulses during beat 10 and during done are both ignored.
    step();
    applyStimulus(32'h0000_01F0, -1, 0, 10, 1'b1, -1, 65);
    step();
    checkOutput("restart_ignored_busy", busy, 0);
    checkOutput("restart_ignored_valid", outValid, 0);

    // Reset mid-dump, then a clean full dump.
    applyStimulus(32'h0000_01F0, -1, 0, -1, 1'b0, 15, 65);
    applyStimulus(32'h0000_01F0, -1, 0, -1, 1'b0, -1, 65);

    // All-ones contents make the checksum wrap.
    step();
    for (int i = 1; i < 32; i++) begin
      regs[i]    = 32'hFFFF_FFFF;
      expData[i] = 32'hFFFF_FFFF;
    end
    applyStimulus(32'hFFFF_FFE1, -1, 0, -1, 1'b0, -1, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Sequential reader for the CPU register file.
- On a start pulse, walks every register through one asynchronous read port. Each value is emitted as an (index, data) beat on a valid/ready stream; a running 32-bit sum is kept as a checksum.
- Used after halt for the testbench register print and debug dump. The core must be stalled (gate write_enable with busy) while busy=1; this block does not arbitrate writes.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin dump; sampled only in IDLE.
- rf_addr  output  ADDR_W  drives the register file read-port address.
- rf_data  input  DATA_W  combinational read data for rf_addr, same cycle.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts beat.
- out_index  output  ADDR_W  register index of the current beat.
- out_data  output  DATA_W  register value of the current beat.
- busy  output  1  high in READ, EMIT, DONE.
- done  output  1  one-cycle pulse when the dump completes.
- checksum  output  DATA_W  sum mod 2**DATA_W of all accepted beats.

Behaviour:
- State machine: IDLE, READ, EMIT, DONE. All outputs are registered or decoded from state only.
- Reset (any state, including mid-dump):
  - state=IDLE, idx=0, out_valid=0, out_index=0, out_data=0, checksum=0, done=0, busy=0.
  - Any beat in flight is dropped.
- IDLE:
  - rf_addr=0.
  - start=1 -> clear checksum and idx to 0, go to READ.
  - start=0 -> stay in IDLE.
- READ:
  - rf_addr=idx.
  - Capture rf_data into out_data and idx into out_index, then go to EMIT.
- EMIT:
  - out_valid=1; out_index and out_data are held stable until the handshake.
  - Handshake is out_valid && out_ready in the same cycle. On handshake, checksum <= checksum + out_data (wraps).
  - On handshake with idx != NUM_REGS-1: idx <= idx+1, go to READ.
  - On handshake with idx == NUM_REGS-1: go to DONE.
  - No handshake: stay in EMIT with outputs unchanged. A stall of any length is legal.
- DONE:
  - done=1 for exactly one cycle; checksum is final and stable.
  - Go to IDLE.
  - checksum holds its value in IDLE until the next accepted start.
- Start handling:
  - start while busy=1 is ignored; there is no queued restart.
  - start asserted in the same cycle as done is ignored. start on the first IDLE cycle after DONE is accepted.
- rf_addr: equals idx in READ and EMIT, 0 in IDLE and DONE.
- Timing: start sampled at cycle T with out_ready held at 1.
  - Beat k is valid in cycle T+2+2k.
  - done=1 in cycle T+65.
  - busy=1 from T+1 through T+65.
  - Throughput is one beat per two cycles.
- Index rules: idx never exceeds NUM_REGS-1. Register 0 is read and emitted like any other register.

Decomposition:
- Shared package rf_dump_pkg holds:
  - state enum (IDLE=2'd0, READ=2'd1, EMIT=2'd2, DONE=2'd3);
  - default widths RF_ADDR_W=5, RF_DATA_W=32;
  - RF_NUM_REGS=32.
- No sub-module: a single FSM with an idx counter and checksum accumulator (about 150 lines of RTL).
- The bench instantiates the existing register file and connects rf_addr to its rs1 address and its rs1 output to rf_data.

Test Plan:
- After register file reset (all 0 except x2=0x2ffc), start pulse, out_ready=1:
  - exactly 32 beats, index 0..31 in order;
  - beat 2 data=0x00002ffc, all other beats 0;
  - done pulse at T+65; checksum=0x00002ffc.
- Write x_i=i for i=1..31 while the block is in IDLE, then dump with out_ready=1 -> beat i data=i, checksum=0x000001F0.
- Same contents, out_ready=0 for 5 cycles during beat 7:
  - out_valid, out_index=7 and out_data=7 held all 5 cycles;
  - checksum does not advance while stalled;
  - final checksum still 0x000001F0; done at T+70.
- start re-pulsed during beat 10 and again in the cycle done=1 -> both ignored; exactly 32 beats and one done pulse.
- reset asserted at beat 15 -> next cycle: out_valid=0, busy=0, checksum=0, state IDLE. A new start then yields a full 32-beat dump from index 0.
- All x_i=0xFFFFFFFF for i=1..31 -> checksum wraps to 0xFFFFFFE1 (31 x 0xFFFFFFFF mod 2**32).
